// File: rtl/fft_pkg.sv
// Shared types, default widths and fixed-point helpers for the
// streaming radix-2 SDF FFT stages.
package fft_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;
    localparam int TW_ONE = (1 << (TW_DEF - 1)) - 1;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    // Clamp v into the signed range of a w-bit value.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Round half up, then arithmetic shift right by s (s >= 1).
    function automatic logic signed [63:0] round_shift(
        input logic signed [63:0] v,
        input int s
    );
        return (v + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Registered complex multiplier; the rounded and saturated result is
// formed combinationally from the product register.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [TW-1:0] b_re,
    input  logic signed [TW-1:0] b_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);

    localparam int PW = DW + TW + 1;

    logic signed [PW-1:0] m_re;
    logic signed [PW-1:0] m_im;
    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;

    always_comb begin
        m_re = PW'(a_re) * PW'(b_re) - PW'(a_im) * PW'(b_im);
        m_im = PW'(a_re) * PW'(b_im) + PW'(a_im) * PW'(b_re);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en) begin
            p_re <= m_re;
            p_im <= m_im;
        end
    end

    // Q1.(TW-1) product back to DW bits; (-1)*(-1) clamps to max.
    assign y_re = DW'(saturate(round_shift(64'(p_re), TW - 1), DW));
    assign y_im = DW'(saturate(round_shift(64'(p_im), TW - 1), DW));

endmodule

// File: rtl/fft_sdf_r2_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage: butterfly against a
// D-deep feedback line, twiddle on the difference branch, 2-cycle latency.
module fft_sdf_r2_stage
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int TW    = TW_DEF,
    parameter int D     = 4,
    parameter int LOG2D = $clog2(D)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 scale,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic [((LOG2D > 0) ? LOG2D : 1)-1:0] tw_idx,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im
);

    localparam int IW = (LOG2D > 0) ? LOG2D : 1;
    localparam int CW = LOG2D + 1;

    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic          primed;
    logic          accept;
    logic          v1;
    phase_e        phase;
    phase_e        s1_phase;

    logic signed [DW-1:0] dl_re [D];
    logic signed [DW-1:0] dl_im [D];
    logic signed [DW-1:0] d_re;
    logic signed [DW-1:0] d_im;
    logic signed [DW:0]   sum_re;
    logic signed [DW:0]   sum_im;
    logic signed [DW:0]   dif_re;
    logic signed [DW:0]   dif_im;
    logic signed [DW-1:0] bs_re;
    logic signed [DW-1:0] bs_im;
    logic signed [DW-1:0] bd_re;
    logic signed [DW-1:0] bd_im;
    logic signed [DW-1:0] s1_re;
    logic signed [DW-1:0] s1_im;
    logic signed [DW-1:0] cm_re;
    logic signed [DW-1:0] cm_im;

    function automatic logic signed [DW-1:0] bfly_scale(
        input logic signed [DW:0] v,
        input logic half
    );
        if (half) return DW'(round_shift(64'(v), 1));
        return DW'(saturate(64'(v), DW));
    endfunction

    generate
        if (D == 1) begin : g_one
            assign ptr = '0;
        end else begin : g_ptr
            assign ptr = cnt[IW-1:0];
        end
    endgenerate

    assign phase  = cnt[CW-1] ? PH_B : PH_A;
    assign accept = in_valid & ~clr;
    assign tw_idx = ptr;
    assign d_re   = dl_re[ptr];
    assign d_im   = dl_im[ptr];

    always_comb begin
        sum_re = {d_re[DW-1], d_re} + {in_re[DW-1], in_re};
        sum_im = {d_im[DW-1], d_im} + {in_im[DW-1], in_im};
        dif_re = {d_re[DW-1], d_re} - {in_re[DW-1], in_re};
        dif_im = {d_im[DW-1], d_im} - {in_im[DW-1], in_im};
        bs_re  = bfly_scale(sum_re, scale);
        bs_im  = bfly_scale(sum_im, scale);
        bd_re  = bfly_scale(dif_re, scale);
        bd_im  = bfly_scale(dif_im, scale);
    end

    // First half stores raw input; second half stores the difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else if (accept) begin
            if (phase == PH_A) begin
                dl_re[ptr] <= in_re;
                dl_im[ptr] <= in_im;
            end else begin
                dl_re[ptr] <= bd_re;
                dl_im[ptr] <= bd_im;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            primed    <= 1'b0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= accept & primed;
            out_valid <= v1;
            if (accept) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(D - 1)) primed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_phase <= PH_A;
            s1_re    <= '0;
            s1_im    <= '0;
            out_re   <= '0;
            out_im   <= '0;
        end else begin
            if (accept) begin
                s1_phase <= phase;
                s1_re    <= bs_re;
                s1_im    <= bs_im;
            end
            if (v1 && !clr) begin
                out_re <= (s1_phase == PH_A) ? cm_re : s1_re;
                out_im <= (s1_phase == PH_A) ? cm_im : s1_im;
            end
        end
    end

    fft_cmul #(
        .DW(DW),
        .TW(TW)
    ) u_cmul (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .a_re (d_re),
        .a_im (d_im),
        .b_re (tw_re),
        .b_im (tw_im),
        .y_re (cm_re),
        .y_im (cm_im)
    );

endmodule

// File: tb/tb_fft_sdf_r2_stage.sv
// Randomised bench for fft_sdf_r2_stage (D=4, DW=TW=16) against a
// frame-level DIF butterfly model with twiddle table W_8^k.
module tb_fft_sdf_r2_stage;
    import fft_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic scale;
    logic in_valid;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic [1:0] tw_idx;
    logic signed [15:0] tw_re;
    logic signed [15:0] tw_im;
    logic out_valid;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;

    int wre[D] = '{TW_ONE, 23170, 0, -23170};
    int wim[D] = '{0, -23170, -32768, -23170};

    typedef struct {
        int due;
        int re;
        int im;
    } ev_t;

    ev_t expq[$];
    ev_t cap[$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int pos;
    int since;
    longint fr[D];
    longint fi[D];
    longint dr[D];
    longint di[D];
    int want_imp[8] = '{100, 0, 0, 0, 100, 0, 0, 0};

    always #5 clk = ~clk;

    always_comb begin
        tw_re = 16'(wre[tw_idx]);
        tw_im = 16'(wim[tw_idx]);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_valid)
            cap.push_back(ev_t'{cyc, int'(out_re), int'(out_im)});

    fft_sdf_r2_stage #(
        .DW(16),
        .TW(16),
        .D(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .scale     (scale),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .tw_idx    (tw_idx),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    function automatic longint satf(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint scl(input longint v, input logic s);
        if (s) return (v + 1) >>> 1;
        return satf(v);
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_clear();
        pos = 0;
        since = 0;
        for (int i = 0; i < D; i++) begin
            fr[i] = 0; fi[i] = 0; dr[i] = 0; di[i] = 0;
        end
        expq.delete();
        cap.delete();
    endtask

    // Sample n of a 2D frame: first half emits previous diffs * W^n,
    // second half emits the sum and keeps the difference.
    task automatic model_accept(input int re, input int im, input logic sc);
        longint o_re, o_im;
        int n;
        n = pos;
        if (n < D) begin
            o_re = satf((dr[n] * wre[n] - di[n] * wim[n] + 16384) >>> 15);
            o_im = satf((dr[n] * wim[n] + di[n] * wre[n] + 16384) >>> 15);
            fr[n] = re;
            fi[n] = im;
        end else begin
            o_re = scl(fr[n-D] + re, sc);
            o_im = scl(fi[n-D] + im, sc);
            dr[n-D] = scl(fr[n-D] - re, sc);
            di[n-D] = scl(fi[n-D] - im, sc);
        end
        if (since >= D)
            expq.push_back(ev_t'{cyc + 2, int'(o_re), int'(o_im)});
        since++;
        pos = (pos + 1) % (2 * D);
    endtask

    task automatic drive(input logic v, input int re, input int im,
                         input logic sc, input logic c);
        in_valid = v;
        in_re = 16'(re);
        in_im = 16'(im);
        scale = sc;
        clr = c;
        if (c) begin
            pos = 0;
            since = 0;
            while (expq.size() > 0 && expq[$].due > cyc)
                void'(expq.pop_back());
        end else if (v) begin
            model_accept(re, im, sc);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        scale = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++)
            drive(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_re !== 16'sd0 || out_im !== 16'sd0) begin
            fails++;
            $display("FAIL reset_out got v=%0d (%0d,%0d) want v=0 (0,0)",
                     out_valid, out_re, out_im);
        end
        tests++;
        if (tw_idx !== 2'd0) begin
            fails++;
            $display("FAIL reset_tw_idx got %0d want 0", tw_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < D; i++) begin
            drive(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL prime_suppress[%0d] got out_valid=%0d want 0",
                         i, out_valid);
            end
        end
        idle(3);
        #1;
        tests++;
        if (cap.size() != 0) begin
            fails++;
            $display("FAIL prime_count got %0d outputs want 0", cap.size());
        end
    endtask

    task automatic test_impulse();
        do_reset();
        for (int i = 0; i < 2 * D; i++)
            drive(1'b1, (i == 0) ? 100 : 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < D; i++)
            drive(1'b1, 0, 0, 1'b0, 1'b0);
        idle(3);
        #1;
        tests++;
        if (cap.size() != 8 || expq.size() != 8) begin
            fails++;
            $display("FAIL impulse_count got %0d want 8 (model %0d)",
                     cap.size(), expq.size());
        end
        for (int i = 0; i < cap.size() && i < 8; i++) begin
            tests++;
            if (cap[i].re !== want_imp[i] || cap[i].im !== 0
                || cap[i].due !== expq[i].due) begin
                fails++;
                $display("FAIL impulse_out[%0d] got t=%0d (%0d,%0d) want t=%0d (%0d,0)",
                         i, cap[i].due, cap[i].re, cap[i].im,
                         expq[i].due, want_imp[i]);
            end
        end
    endtask

    task automatic test_twiddle();
        do_reset();
        for (int i = 0; i < 2 * D; i++)
            drive(1'b1, (i == 2) ? 64 : 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < D; i++)
            drive(1'b1, 0, 0, 1'b0, 1'b0);
        idle(3);
        #1;
        tests++;
        if (cap.size() != 8) begin
            fails++;
            $display("FAIL twiddle_count got %0d want 8", cap.size());
        end else begin
            tests++;
            if (cap[2].re !== 64 || cap[2].im !== 0) begin
                fails++;
                $display("FAIL twiddle_sum2 got (%0d,%0d) want (64,0)",
                         cap[2].re, cap[2].im);
            end
            tests++;
            if (cap[6].re !== 0 || cap[6].im !== -64) begin
                fails++;
                $display("FAIL twiddle_minus_j got (%0d,%0d) want (0,-64)",
                         cap[6].re, cap[6].im);
            end
        end
    endtask

    task automatic test_saturation();
        int v[3] = '{32767, 32767, -32768};
        logic s[3] = '{1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            do_reset();
            for (int i = 0; i < 2 * D; i++)
                drive(1'b1, (i % D == 0) ? v[c] : 0, 0, s[c], 1'b0);
            idle(3);
            #1;
            tests++;
            if (cap.size() == 0) begin
                fails++;
                $display("FAIL sat_case%0d got no output want %0d", c, v[c]);
            end else if (cap[0].re !== v[c] || cap[0].im !== 0) begin
                fails++;
                $display("FAIL sat_case%0d got (%0d,%0d) want (%0d,0)",
                         c, cap[0].re, cap[0].im, v[c]);
            end
        end
    endtask

    task automatic test_stalls();
        do_reset();
        for (int i = 0; i < 3 * D; i++) begin
            repeat ($urandom_range(0, 2)) begin
                drive(1'b0, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b0);
                tests++;
                if (tw_idx !== 2'(pos % D)) begin
                    fails++;
                    $display("FAIL stall_tw_idx got %0d want %0d",
                             tw_idx, pos % D);
                end
            end
            drive(1'b1, (i == 0) ? 100 : 0, 0, 1'b0, 1'b0);
        end
        idle(3);
        #1;
        tests++;
        if (cap.size() != 8 || expq.size() != 8) begin
            fails++;
            $display("FAIL stall_count got %0d want 8 (model %0d)",
                     cap.size(), expq.size());
        end
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            tests++;
            if (cap[i].re !== want_imp[i] || cap[i].im !== 0
                || cap[i].due !== expq[i].due) begin
                fails++;
                $display("FAIL stall_out[%0d] got t=%0d (%0d,%0d) want t=%0d (%0d,0)",
                         i, cap[i].due, cap[i].re, cap[i].im,
                         expq[i].due, want_imp[i]);
            end
        end
    endtask

    task automatic test_clr();
        int n;
        do_reset();
        for (int i = 0; i < 2 * D + 2; i++)
            drive(1'b1, rnd16() / 4, rnd16() / 4, 1'b0, 1'b0);
        drive(1'b1, 1234, 567, 1'b0, 1'b1);
        for (int i = 0; i < 3 * D; i++)
            drive(1'b1, (i == 0) ? 100 : 0, 0, 1'b0, 1'b0);
        idle(3);
        #1;
        tests++;
        if (cap.size() != expq.size() || cap.size() != 13) begin
            fails++;
            $display("FAIL clr_count got %0d want 13 (model %0d)",
                     cap.size(), expq.size());
        end
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            tests++;
            if (cap[i].due !== expq[i].due || cap[i].re !== expq[i].re
                || cap[i].im !== expq[i].im) begin
                fails++;
                $display("FAIL clr_out[%0d] got t=%0d (%0d,%0d) want t=%0d (%0d,%0d)",
                         i, cap[i].due, cap[i].re, cap[i].im,
                         expq[i].due, expq[i].re, expq[i].im);
            end
        end
        n = cap.size();
        for (int i = 0; i < 8 && n >= 8; i++) begin
            tests++;
            if (cap[n-8+i].re !== want_imp[i] || cap[n-8+i].im !== 0) begin
                fails++;
                $display("FAIL clr_restart[%0d] got (%0d,%0d) want (%0d,0)",
                         i, cap[n-8+i].re, cap[n-8+i].im, want_imp[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 6 * 2 * D; i++) begin
            if ($urandom_range(0, 9) < 3)
                drive(1'b0, rnd16(), rnd16(), 1'b0, 1'b0);
            drive(1'b1, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < D; i++)
            drive(1'b1, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b0);
        idle(3);
        #1;
        tests++;
        if (cap.size() != expq.size()) begin
            fails++;
            $display("FAIL random_count got %0d want %0d",
                     cap.size(), expq.size());
        end
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            tests++;
            if (cap[i].due !== expq[i].due || cap[i].re !== expq[i].re
                || cap[i].im !== expq[i].im) begin
                fails++;
                $display("FAIL random_out[%0d] got t=%0d (%0d,%0d) want t=%0d (%0d,%0d)",
                         i, cap[i].due, cap[i].re, cap[i].im,
                         expq[i].due, expq[i].re, expq[i].im);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        scale = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        pos = 0;
        since = 0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_twiddle();
        test_saturation();
        test_stalls();
        test_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
